// File: rtl/operand_fetch.sv
// Operand fetch: reads two source registers with 1-cycle RF latency, forwarding in-flight writebacks.
// Accept-to-op_valid is 2 cycles; stalls while op_ready=0 and accepts a new pair in the consuming cycle.
module operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_addr_a,
  input  logic [4:0]  req_addr_b,
  output logic [4:0]  rf_read_addr_a,
  output logic [4:0]  rf_read_addr_b,
  input  logic [31:0] rf_read_data_a,
  input  logic [31:0] rf_read_data_b,
  input  logic        wb_enable,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [4:0]  op_addr_a,
  output logic [4:0]  op_addr_b
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [4:0]  r_addr_a;
  logic [4:0]  r_addr_b;
  logic        r_fwd_a;
  logic        r_fwd_b;
  logic [31:0] r_fwd_data_a;
  logic [31:0] r_fwd_data_b;

  logic        w_req_ready;
  logic        w_accept;
  logic        w_acc_hit_a;
  logic        w_acc_hit_b;
  logic        w_wb_hit_a;
  logic        w_wb_hit_b;
  logic [31:0] w_fetch_a;
  logic [31:0] w_fetch_b;

  always_comb begin
    w_req_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE:    w_req_ready = 1'b1;
        VALID:   w_req_ready = op_ready;
        default: w_req_ready = 1'b0;
      endcase
    end
  end

  assign w_accept  = req_valid & w_req_ready;
  assign req_ready = w_req_ready;

  // The RF sees the incoming addresses in the accept cycle, the held pair otherwise.
  assign rf_read_addr_a = w_req_ready ? req_addr_a : r_addr_a;
  assign rf_read_addr_b = w_req_ready ? req_addr_b : r_addr_b;

  // Accept-cycle writes are missed by the RF read, so they are captured here.
  assign w_acc_hit_a = wb_enable && (wb_addr == req_addr_a);
  assign w_acc_hit_b = wb_enable && (wb_addr == req_addr_b);

  assign w_wb_hit_a = wb_enable && (wb_addr == r_addr_a);
  assign w_wb_hit_b = wb_enable && (wb_addr == r_addr_b);

  always_comb begin
    w_fetch_a = rf_read_data_a;
    w_fetch_b = rf_read_data_b;
    if (w_wb_hit_a)   w_fetch_a = wb_data;
    else if (r_fwd_a) w_fetch_a = r_fwd_data_a;
    if (w_wb_hit_b)   w_fetch_b = wb_data;
    else if (r_fwd_b) w_fetch_b = r_fwd_data_b;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = FETCH;
      FETCH:   w_state_nxt = VALID;
      VALID:   if (op_ready) w_state_nxt = w_accept ? FETCH : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_addr_a     <= '0;
      r_addr_b     <= '0;
      r_fwd_a      <= 1'b0;
      r_fwd_b      <= 1'b0;
      r_fwd_data_a <= '0;
      r_fwd_data_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr_a     <= req_addr_a;
        r_addr_b     <= req_addr_b;
        r_fwd_a      <= w_acc_hit_a;
        r_fwd_b      <= w_acc_hit_b;
        r_fwd_data_a <= wb_data;
        r_fwd_data_b <= wb_data;
      end
      case (r_state)
        FETCH: begin
          r_op_a <= w_fetch_a;
          r_op_b <= w_fetch_b;
        end
        VALID: begin
          // While stalled, keep the held operands coherent with the RF.
          if (!op_ready && w_wb_hit_a) r_op_a <= wb_data;
          if (!op_ready && w_wb_hit_b) r_op_b <= wb_data;
        end
        default: ;
      endcase
    end
  end

  assign op_valid  = (r_state == VALID);
  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign op_addr_a = r_addr_a;
  assign op_addr_b = r_addr_b;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: behavioural register file plus a transaction-level model of accepted pairs.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr_a, req_addr_b;
  logic [4:0]  rf_read_addr_a, rf_read_addr_b;
  logic [31:0] rf_read_data_a, rf_read_data_b;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_addr_a, op_addr_b;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
    .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
    .rf_read_data_a(rf_read_data_a), .rf_read_data_b(rf_read_data_b),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_addr_a(op_addr_a), .op_addr_b(op_addr_b)
  );

  // Register file: registered read returns the value before a same-edge write.
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    rf_read_data_a <= rf_mem[rf_read_addr_a];
    rf_read_data_b <= rf_mem[rf_read_addr_b];
    if (wb_enable) rf_mem[wb_addr] <= wb_data;
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Model: a pair accepted in cycle T is held (op_valid) from T+2 until consumed;
  // while held, each operand must equal the current architectural register value.
  bit       m_pend = 1'b0, m_hold = 1'b0, m_after_rst = 1'b0;
  logic [4:0] m_fa = '0, m_fb = '0, m_ha = '0, m_hb = '0, m_la = '0, m_lb = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit v, input logic [4:0] a, input logic [4:0] b,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd, input bit ordy);
    rst = r; req_valid = v; req_addr_a = a; req_addr_b = b;
    wb_enable = we; wb_addr = wa; wb_data = wd; op_ready = ordy;
  endtask

  task automatic step();
    bit exp_rdy, acc;
    @(negedge clk);
    exp_rdy = !rst && !m_pend && (!m_hold || op_ready);
    chk("req_ready", {31'b0, req_ready}, {31'b0, exp_rdy});
    chk("op_valid", {31'b0, op_valid}, {31'b0, m_hold});
    if (!rst) begin
      chk("rf_addr_a", {27'b0, rf_read_addr_a}, {27'b0, exp_rdy ? req_addr_a : m_la});
      chk("rf_addr_b", {27'b0, rf_read_addr_b}, {27'b0, exp_rdy ? req_addr_b : m_lb});
    end
    if (m_hold) begin
      chk("op_addr_a", {27'b0, op_addr_a}, {27'b0, m_ha});
      chk("op_addr_b", {27'b0, op_addr_b}, {27'b0, m_hb});
      chk("op_a", op_a, rf_mem[m_ha]);
      chk("op_b", op_b, rf_mem[m_hb]);
    end
    if (m_after_rst) begin
      chk("rst_op_a", op_a, 32'h0);
      chk("rst_op_b", op_b, 32'h0);
      chk("rst_addrs", {22'b0, op_addr_a, op_addr_b}, 32'h0);
    end
    acc = req_valid && exp_rdy;
    if (rst) begin
      m_pend = 1'b0; m_hold = 1'b0; m_la = '0; m_lb = '0; m_after_rst = 1'b1;
    end else begin
      m_after_rst = 1'b0;
      if (m_hold && op_ready) m_hold = 1'b0;
      if (m_pend) begin
        m_hold = 1'b1; m_ha = m_fa; m_hb = m_fb;
      end
      m_pend = acc;
      if (acc) begin
        m_fa = req_addr_a; m_fb = req_addr_b; m_la = req_addr_a; m_lb = req_addr_b;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [6:0] b2b_pat;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    // Preload the register file through the writeback port while in reset.
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 0, 1, 5'(i), $urandom, 0);
      step();
    end
    drive(1, 0, 0, 0, 1, 5'd3, 32'h11, 0);   step();
    drive(1, 0, 0, 0, 1, 5'd7, 32'h22, 0);   step();
    drive(1, 0, 0, 0, 1, 5'd5, 32'h0, 0);    step();
    drive(1, 0, 0, 0, 1, 5'd6, 32'h55, 0);   step();
    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("idle_req_ready", {31'b0, req_ready}, 32'h1);
    chk("idle_op_valid", {31'b0, op_valid}, 32'h0);

    // Basic fetch of (3,7).
    drive(0, 1, 5'd3, 5'd7, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1);       step();
    chk("basic_vld", {31'b0, op_valid}, 32'h1);
    chk("basic_a", op_a, 32'h11);
    chk("basic_b", op_b, 32'h22);
    chk("basic_tags", {22'b0, op_addr_a, op_addr_b}, {22'b0, 5'd3, 5'd7});

    // Accept-cycle forwarding on port A (accepted in the consuming VALID cycle).
    drive(0, 1, 5'd5, 5'd6, 1, 5'd5, 32'hDEADBEEF, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1);                     step();
    chk("accfwd_a", op_a, 32'hDEADBEEF);
    chk("accfwd_b", op_b, 32'h55);

    // FETCH-cycle forwarding on port B.
    drive(0, 1, 5'd5, 5'd6, 0, 0, 0, 1);     step();
    drive(0, 0, 0, 0, 1, 5'd6, 32'h1234, 1); step();
    chk("fetchfwd_a", op_a, 32'hDEADBEEF);
    chk("fetchfwd_b", op_b, 32'h1234);

    // Stall update with both ports on r9.
    drive(0, 1, 5'd9, 5'd9, 0, 0, 0, 1);     step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);           step();
    drive(0, 0, 0, 0, 1, 5'd9, 32'hCAFE, 0); step();
    chk("stall_vld", {31'b0, op_valid}, 32'h1);
    chk("stall_a", op_a, 32'hCAFE);
    chk("stall_b", op_b, 32'hCAFE);
    drive(0, 0, 0, 0, 0, 0, 0, 1);           step();

    // Back-to-back throughput: one pair every 2 cycles.
    b2b_pat = 7'b0010101;
    for (int k = 0; k < 7; k++) begin
      chk("b2b_vld", {31'b0, op_valid}, {31'b0, b2b_pat[6-k]});
      drive(0, 1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 1);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1); step(); step();

    // Reset in the FETCH cycle discards the request.
    drive(0, 1, 5'd3, 5'd7, 0, 0, 0, 1); step();
    drive(1, 0, 0, 0, 0, 0, 0, 1);       step();
    chk("midrst_vld", {31'b0, op_valid}, 32'h0);
    chk("midrst_a", op_a, 32'h0);
    chk("midrst_b", op_b, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("midrst_rdy", {31'b0, req_ready}, 32'h1);
    step(); step();

    // Random traffic with narrow address range to provoke hazards.
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
